// File: rtl/comp_mult_pkg.sv
// ==== comp_mult_pkg : shared state encoding and width helpers for comp_mult_arb (rev 1.0) ====
`default_nettype none

package comp_mult_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  localparam int DEF_DWIDTH   = 8;
  localparam int DEF_OP_W     = 4 * DEF_DWIDTH;
  localparam int DEF_RES_W    = 4 * (DEF_DWIDTH + 1);

  function automatic int op_word_w(input int dwidth);
    return 4 * dwidth;
  endfunction

  function automatic int res_word_w(input int dwidth);
    return 4 * (dwidth + 1);
  endfunction

  function automatic int grant_w(input int nreq);
    return (nreq > 1) ? $clog2(nreq) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/comp_mult_arb_rr_pick.sv
// ==== rr_pick : combinational round-robin winner search starting at prio_ptr (rev 1.0) ====
`default_nettype none

module rr_pick
  import comp_mult_pkg::*;
#(
  parameter int NREQ = 4,
  localparam int GW  = grant_w(NREQ)
) (
  input  logic [NREQ-1:0] req_val,
  input  logic [GW-1:0]   prio_ptr,
  output logic [GW-1:0]   winner,
  output logic            any_req
);

  logic found;

  // prio_ptr is always below NREQ, so one conditional subtract implements the wrap
  always_comb begin
    int idx;
    winner = '0;
    found  = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(prio_ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && req_val[idx]) begin
        found  = 1'b1;
        winner = GW'(idx);
      end
    end
  end

  assign any_req = |req_val;

endmodule

`default_nettype wire

// File: rtl/comp_mult_arb.sv
// ==== comp_mult_arb : round-robin arbiter/sequencer sharing one complex multiplier (rev 1.0) ====
`default_nettype none

module comp_mult_arb
  import comp_mult_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int DWIDTH = 8,
  localparam int GW    = grant_w(NREQ),
  localparam int OPW   = op_word_w(DWIDTH),
  localparam int RESW  = res_word_w(DWIDTH)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                sw_rst,
  input  logic [NREQ-1:0]     req_val,
  output logic [NREQ-1:0]     req_rdy,
  input  logic [NREQ*OPW-1:0] req_data,
  output logic [NREQ-1:0]     rsp_val,
  input  logic [NREQ-1:0]     rsp_rdy,
  output logic [RESW-1:0]     rsp_data,
  output logic                mul_op_val,
  input  logic                mul_op_rdy,
  output logic [OPW-1:0]      mul_op_data,
  input  logic                mul_res_val,
  output logic                mul_res_rdy,
  input  logic [RESW-1:0]     mul_res_data,
  output logic                busy,
  output logic [GW-1:0]       grant_idx
);

  state_t        state, state_nxt;
  logic [GW-1:0] prio_ptr;
  logic [GW-1:0] winner;
  logic          any_req;
  logic          res_done;
  logic [GW-1:0] ptr_after_grant;

  rr_pick #(.NREQ(NREQ)) u_rr_pick (
    .req_val  (req_val),
    .prio_ptr (prio_ptr),
    .winner   (winner),
    .any_req  (any_req)
  );

  assign res_done        = (state == WAIT) && mul_res_val && rsp_rdy[grant_idx];
  assign ptr_after_grant = (grant_idx == GW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      prio_ptr  <= '0;
      grant_idx <= '0;
    end else if (sw_rst) begin
      state     <= IDLE;
      prio_ptr  <= '0;
      grant_idx <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && any_req) grant_idx <= winner;
      if (res_done) prio_ptr <= ptr_after_grant;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req)    state_nxt = ISSUE;
      ISSUE:   if (mul_op_rdy) state_nxt = WAIT;
      WAIT:    if (res_done)   state_nxt = IDLE;
      default:                 state_nxt = IDLE;
    endcase
  end

  // Pure decode: the multiplier owns the only data storage on this path
  always_comb begin
    req_rdy     = '0;
    rsp_val     = '0;
    mul_op_val  = 1'b0;
    mul_res_rdy = 1'b0;
    mul_op_data = req_data[grant_idx*OPW +: OPW];
    rsp_data    = mul_res_data;
    busy        = (state != IDLE);
    case (state)
      ISSUE: begin
        mul_op_val         = 1'b1;
        req_rdy[grant_idx] = mul_op_rdy;
      end
      WAIT: begin
        rsp_val[grant_idx] = mul_res_val;
        mul_res_rdy        = rsp_rdy[grant_idx];
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire
